ysyx_24100005_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store port.
- Accepts one request at a time on a valid/ready request channel and services it against an internal word-addressed SRAM array after a configurable latency.
- Returns read data or a write acknowledge on a valid/ready response channel.
- Replaces the DPI-C memory path as the synthesizable far end of the same load/store interface.

---
 rtl/ysyx_24100005_mem_pkg.sv | 21 ++
 rtl/ysyx_24100005_lfsr8.sv | 34 +++
 rtl/ysyx_24100005_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_ysyx_24100005_mem_responder.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_mem_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24100005_mem_pkg
// Shared definitions for the synthesizable load/store memory responder:
//   - state_e          : responder FSM state (IDLE / WAIT / RESP), 2 bits
//   - DEFAULT_BASE_ADDR: first byte address mapped onto the SRAM array
//   - XLEN, MASK_W     : data word width and byte-strobe width
// ----------------------------------------------------------------------------
package ysyx_24100005_mem_pkg;

  localparam int XLEN   = 32;
  localparam int MASK_W = 4;

  localparam logic [XLEN-1:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_24100005_lfsr8.sv
// ----------------------------------------------------------------------------
// ysyx_24100005_lfsr8
// 8-bit Fibonacci LFSR, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), seeded with 8'hA5
// by a synchronous active-low reset. Advances every clock cycle.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-low
//   out[7:0] out  current LFSR state
// ----------------------------------------------------------------------------
module ysyx_24100005_lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Tap numbering is 1-based: tap 8 is bit 7, tap 6 is bit 5, etc.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/ysyx_24100005_mem_responder.sv
// ----------------------------------------------------------------------------
// ysyx_24100005_mem_responder
// Synthesizable far end of the core's load/store port. Accepts one request at
// a time, waits LATENCY cycles, performs the access against an internal
// word-addressed SRAM array, then presents the response until it is taken.
//
// Optional feature: define YSYX_24100005_RAND_DELAY_EN to add 0..7 extra
// wait cycles per request, drawn from an 8-bit LFSR.
//
// Parameters:
//   BASE_ADDR  first byte address mapped onto the array
//   DEPTH      number of 32-bit words (power of 2)
//   LATENCY    wait cycles between accept and array access (0..15)
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-low
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (IDLE and not in reset)
//   req_wen    in   1 = store, 0 = load
//   req_addr   in   byte address, bits [1:0] ignored
//   req_wdata  in   store data, byte-lane aligned
//   req_wmask  in   byte strobes for stores
//   rsp_valid  out  response present
//   rsp_ready  in   core accepts the response
//   rsp_rdata  out  load data; 0 for stores and errors
//   rsp_err    out  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH)
// ----------------------------------------------------------------------------
module ysyx_24100005_mem_responder
  import ysyx_24100005_mem_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int              DEPTH     = 4096,
  parameter int              LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int         AW    = $clog2(DEPTH);
  localparam logic [4:0] LAT_C = 5'(LATENCY);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // Latched request; data only, so no reset.
  logic              wen_q;
  logic [XLEN-3:0]   waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic              load_req;
  logic              mem_we;
  logic [4:0]        extra_dly;
  logic [XLEN-3:0]   woff;
  logic              in_range;
  logic [AW-1:0]     idx;

  logic [XLEN-1:0]   mem_q [DEPTH];

  // Byte-offset bits never participate in the word decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

`ifdef YSYX_24100005_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic       unused_lfsr_bits;

  ysyx_24100005_lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  assign extra_dly        = {2'b00, lfsr[2:0]};
  assign unused_lfsr_bits = ^lfsr[7:3];
`else
  assign extra_dly = 5'd0;
`endif

  // Word-granular offset: wraps modulo 2^30 words, which is the same as
  // byte arithmetic modulo 2^32 with the low two bits dropped. Addresses
  // below BASE_ADDR wrap to huge offsets and fall out of range.
  assign woff     = waddr_q - BASE_ADDR[XLEN-1:2];
  assign in_range = (woff[XLEN-3:AW] == '0);
  assign idx      = woff[AW-1:0];

  assign req_ready = (state_q == IDLE) && rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // cnt counts remaining wait cycles; the access happens on the edge where
  // WAIT sees cnt==0, so rsp_valid rises delay+1 edges after accept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    load_req    = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_req = 1'b1;
          cnt_d    = LAT_C + extra_dly;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 5'd0) begin
          state_d     = RESP;
          rsp_err_d   = !in_range;
          rsp_rdata_d = (!wen_q && in_range) ? mem_q[idx] : '0;
          mem_we      = wen_q && in_range;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_req) begin
      wen_q   <= req_wen;
      waddr_q <= req_addr[XLEN-1:2];
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  // Gated by rst so a store caught by reset on its access edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && rst) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wmask_q[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_mem_responder.sv
module tb_ysyx_24100005_mem_responder;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef YSYX_24100005_RAND_DELAY_EN
  localparam int EXTRA_MAX = 7;
`else
  localparam int EXTRA_MAX = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wmask;

  logic        z_req_valid, z_req_ready, z_req_wen, z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_wmask;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [int];

  ysyx_24100005_mem_responder #(.BASE_ADDR(BASE), .DEPTH(4096), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  ysyx_24100005_mem_responder #(.BASE_ADDR(BASE), .DEPTH(4096), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_wen(z_req_wen),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wmask(z_req_wmask),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  // ---------------- reference model ----------------
  function automatic bit in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'h0000_4000;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Expected response for one request; updates the model for stores.
  task automatic model_apply(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] m, output logic [31:0] exp_rd,
                             output logic exp_err);
    int i;
    exp_rd  = 32'h0;
    exp_err = !in_range(a);
    if (!exp_err) begin
      i = word_idx(a);
      if (wen) begin
        if (model_mem.exists(i)) model_mem[i] = merge(model_mem[i], wd, m);
        else model_mem[i] = merge(32'h0, wd, m);
      end else if (model_mem.exists(i)) begin
        exp_rd = model_mem[i];
      end
    end
  endtask

  // ---------------- drivers ----------------
  // One transaction on the main DUT with rsp_ready held high; dly is the
  // number of edges from accept to rsp_valid (-1 on timeout).
  task automatic txn(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] m, output logic [31:0] rd, output logic er,
                     output int dly);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = wd; req_wmask = m;
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    dly = -1; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        dly = k;
        break;
      end
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic z_txn(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, output logic [31:0] rd, output logic er,
                       output int dly);
    int n;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_wen = wen; z_req_addr = a; z_req_wdata = wd; z_req_wmask = m;
    z_rsp_ready = 1'b1;
    n = 0;
    while (!z_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    z_req_valid = 1'b0;
    dly = -1; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (z_rsp_valid) begin
        dly = k;
        break;
      end
    end
    rd = z_rsp_rdata;
    er = z_rsp_err;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || z_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b z_req_ready=%b, required 0 0 0",
               req_ready, rsp_valid, z_req_ready);
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h err=%b, required 0 0", rsp_rdata, rsp_err);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd, erd;
    logic er, eer;
    int dly;
    txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, dly);
    model_apply(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, erd, eer);
    checks++;
    if (dly < LAT + 1 || dly > LAT + 1 + EXTRA_MAX) begin
      errors++;
      $display("FAIL basic_store_delay: got %0d, required %0d..%0d", dly, LAT + 1, LAT + 1 + EXTRA_MAX);
    end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL basic_store_rsp: err=%b rdata=%h, required 0 00000000", er, rd);
    end
    txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, dly);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL basic_load: rdata=%h err=%b, required deadbeef 0", rd, er);
    end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd, erd;
    logic er, eer;
    int dly;
    txn(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, rd, er, dly);
    model_apply(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, erd, eer);
    txn(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, rd, er, dly);
    model_apply(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, erd, eer);
    txn(1'b1, 32'h8000_0022, 32'hFFFF_FFFF, 4'h0, rd, er, dly);
    checks++;
    if (er !== 1'b0 || dly < 1) begin
      errors++;
      $display("FAIL zero_mask_rsp: err=%b dly=%0d, required 0 and a response", er, dly);
    end
    txn(1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, dly);
    checks++;
    if (rd !== 32'h11BB_33DD) begin
      errors++;
      $display("FAIL byte_mask_load: rdata=%h, required 11bb33dd", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, erd;
    logic er, eer;
    int dly;
    txn(1'b1, 32'h8000_0000, 32'h5A5A_1234, 4'hF, rd, er, dly);
    model_apply(1'b1, 32'h8000_0000, 32'h5A5A_1234, 4'hF, erd, eer);
    txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF, rd, er, dly);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_load: err=%b rdata=%h, required 1 00000000", er, rd);
    end
    checks++;
    if (dly < LAT + 1 || dly > LAT + 1 + EXTRA_MAX) begin
      errors++;
      $display("FAIL oor_delay: got %0d, required %0d..%0d", dly, LAT + 1, LAT + 1 + EXTRA_MAX);
    end
    txn(1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, rd, er, dly);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL oor_store: err=%b, required 1", er);
    end
    txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, dly);
    checks++;
    if (rd !== 32'h5A5A_1234 || er !== 1'b0) begin
      errors++;
      $display("FAIL oor_no_write: rdata=%h err=%b, required 5a5a1234 0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd;
    logic er, eer;
    int dly, n;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = 4'h0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    // Offer a store while the response is stalled; it must wait.
    req_valid = 1'b1; req_wen = 1'b1; req_wdata = 32'h0BAD_C0DE; req_wmask = 4'hF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid=%b rdata=%h req_ready=%b, required 1 deadbeef 0",
                 c, rsp_valid, rsp_rdata, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_apply(1'b1, 32'h8000_0010, 32'h0BAD_C0DE, 4'hF, erd, eer);
    dly = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        dly = k;
        break;
      end
    end
    checks++;
    if (dly < LAT + 1 || dly > LAT + 1 + EXTRA_MAX) begin
      errors++;
      $display("FAIL held_req_delay: got %0d, required %0d..%0d", dly, LAT + 1, LAT + 1 + EXTRA_MAX);
    end
    @(posedge clk);
    #1;
    txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, dly);
    model_apply(1'b0, 32'h8000_0010, 32'h0, 4'h0, erd, eer);
    checks++;
    if (rd !== erd) begin
      errors++;
      $display("FAIL held_req_data: rdata=%h, required %h", rd, erd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd;
    logic er, eer;
    int dly;
    bit seen;
    txn(1'b1, 32'h8000_0040, 32'h1234_5678, 4'hF, rd, er, dly);
    model_apply(1'b1, 32'h8000_0040, 32'h1234_5678, 4'hF, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0040;
    req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ctrl: req_ready=%b rsp_valid=%b, required 0 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: req_ready=%b, required 1", req_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_rsp: rsp_valid rose=%b, required 0", seen);
    end
    txn(1'b0, 32'h8000_0040, 32'h0, 4'h0, rd, er, dly);
    model_apply(1'b0, 32'h8000_0040, 32'h0, 4'h0, erd, eer);
    checks++;
    if (rd !== erd) begin
      errors++;
      $display("FAIL reset_mid_data: rdata=%h, required %h", rd, erd);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, v;
    logic er;
    int dly;
    v = $urandom;
    z_txn(1'b1, 32'h8000_0080, v, 4'hF, rd, er, dly);
    checks++;
    if (dly < 1 || dly > 1 + EXTRA_MAX || er !== 1'b0) begin
      errors++;
      $display("FAIL lat0_store: dly=%0d err=%b, required %0d..%0d 0", dly, er, 1, 1 + EXTRA_MAX);
    end
    z_txn(1'b0, 32'h8000_0080, 32'h0, 4'h0, rd, er, dly);
    checks++;
    if (dly < 1 || dly > 1 + EXTRA_MAX || rd !== v) begin
      errors++;
      $display("FAIL lat0_load: dly=%0d rdata=%h, required %0d..%0d %h", dly, rd, 1, 1 + EXTRA_MAX, v);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd;
    logic er, eer, wen;
    logic [3:0] m;
    int dly, sel;
    for (int i = 0; i < 16; i++) begin
      a = 32'h8000_0200 + 32'(4 * i);
      wd = $urandom;
      txn(1'b1, a, wd, 4'hF, rd, er, dly);
      model_apply(1'b1, a, wd, 4'hF, erd, eer);
    end
    for (int t = 0; t < 200; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) a = BASE - 32'(4 * $urandom_range(1, 1000));
      else if (sel == 1) a = 32'h8000_4000 + ($urandom_range(0, 32'h0FFF_FFFF) & 32'hFFFF_FFFC);
      else a = 32'h8000_0200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      wen = 1'($urandom_range(0, 1));
      wd  = $urandom;
      m   = 4'($urandom_range(0, 15));
      txn(wen, a, wd, m, rd, er, dly);
      model_apply(wen, a, wd, m, erd, eer);
      checks++;
      if (dly < LAT + 1 || dly > LAT + 1 + EXTRA_MAX) begin
        errors++;
        $display("FAIL rand_delay[%0d]: got %0d, required %0d..%0d", t, dly, LAT + 1, LAT + 1 + EXTRA_MAX);
      end
      checks++;
      if (rd !== erd || er !== eer) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: wen=%b addr=%h rdata=%h err=%b, required %h %b",
                 t, wen, a, rd, er, erd, eer);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_wen = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_wmask = '0;
    z_rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_byte_mask();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_latency0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
